l1dc_sync_unit: RTL
===================

# l1dc_sync_unit

- Responder side of the L1 d-cache → L2 synchronisation handshake.
- The main control unit raises `synch_l1dc_l2c_i` and keeps it high while `l2c_update_done_o` is low.
- When it sees the request, this block walks every line of the L1 d-cache directory. Each valid, dirty line is written back to L2 through a valid/ready request/answer channel, and its dirty bit is then cleared. When the walk ends, the block reports completion on `l2c_update_done_o`.
- It sits between the control unit, the L1 d-cache directory/data arrays and the L2 arbiter.

## Interface
Parameters:
- `N_SETS`, 64: d-cache sets; power of 2, ≥2.
- `N_WAYS`, 4: d-cache ways; power of 2, ≥1.
- `LINE_W`, 512: line width in bits; byte offset width `OFF_W` = log2(`LINE_W`/8).
- `PADDR_W`, 56: physical address width. `SET_W` = log2(`N_SETS`), `WAY_W` = max(1, log2(`N_WAYS`)), `TAG_W` = `PADDR_W` − `SET_W` − `OFF_W`.

Ports:
- `clk_i`, in, 1: clock. One clock domain; all state updates on its rising edge.
- `rst_n_i`, in, 1: reset. Asynchronous, active-low.
- `synch_l1dc_l2c_i`, in, 1: level sync request from the control unit.
- `l2c_update_done_o`, out, 1: sync complete. Level output, high in DONE only.
- `busy_o`, out, 1: high in every state except IDLE.
- `dir_rd_req_o`, out, 1: directory/data read strobe.
- `dir_idx_o`, out, `SET_W`: set index for read and clear.
- `dir_way_o`, out, `WAY_W`: way index for read and clear.
- `dir_valid_i`, in, 1: line valid bit. Valid one cycle after `dir_rd_req_o`.
- `dir_dirty_i`, in, 1: line dirty bit. Same timing.
- `dir_tag_i`, in, `TAG_W`: line tag. Same timing.
- `dir_line_i`, in, `LINE_W`: line data. Same timing.
- `dirty_clr_o`, out, 1: clear dirty bit at `dir_idx_o`/`dir_way_o`; one-cycle pulse.
- `l2_req_valid_o`, out, 1: write-back request valid.
- `l2_req_rdy_i`, in, 1: L2 accepts the request.
- `l2_req_addr_o`, out, `PADDR_W`: {tag, set, `OFF_W`'b0}.
- `l2_req_line_o`, out, `LINE_W`: write-back data.
- `l2_ans_valid_i`, in, 1: L2 write acknowledge.
- `l2_ans_rdy_o`, out, 1: ready for the acknowledge.

## Operation
Line counter:
- `cnt` is `SET_W`+`WAY_W` bits (way width is 0 bits when `N_WAYS`=1).
- `dir_way_o` is the low bits of `cnt`; `dir_idx_o` is the high bits.
- `last` = (`cnt` == `N_SETS`·`N_WAYS`−1).

States (all outputs are low unless stated for that state):
- IDLE: `cnt`=0. If `synch_l1dc_l2c_i` → READ.
- READ: `dir_rd_req_o`=1 → CHECK.
- CHECK:
  - If `dir_valid_i`&`dir_dirty_i`: register {`dir_tag_i`, `dir_idx_o`, 0} into `l2_req_addr_o` and `dir_line_i` into `l2_req_line_o` → WB_REQ.
  - Otherwise: if `last` → DONE, else increment `cnt` → READ.
- WB_REQ: `l2_req_valid_o`=1. Address and data stay stable until `l2_req_rdy_i`; on ready → WB_ANS.
- WB_ANS: `l2_ans_rdy_o`=1. On `l2_ans_valid_i` → CLEAR.
- CLEAR: `dirty_clr_o`=1 (indices still point at the current line). If `last` → DONE, else increment `cnt` → READ.
- DONE: `l2c_update_done_o`=1. When `synch_l1dc_l2c_i`=0 → IDLE; otherwise stay.

Boundary rules:
- If `synch_l1dc_l2c_i` drops mid-walk, the walk runs to completion anyway (no abort). DONE then lasts exactly one cycle.
- `l2_ans_valid_i` outside WB_ANS is ignored; `l2_ans_rdy_o` is 0 there.
- `l2_req_rdy_i` outside WB_REQ is ignored.
- Invalid-but-dirty lines are not written back.
- `cnt` never wraps. At `last` the next state is DONE, never READ of index 0.
- A new request while in DONE is not a new sync. A fresh sync requires passing through IDLE.

## Timing
- Reset: state=IDLE, `cnt`=0, all outputs 0, including address/line registers.
- Reset mid-walk returns to IDLE immediately. Dirty bits already cleared stay cleared; the L2 transaction is abandoned.
- Request sampled in IDLE at edge k: READ at cycle k+1, first `dir_rd_req_o` at k+1.
- Clean or invalid line: 2 cycles (READ, CHECK).
- Dirty line: 5 cycles (READ, CHECK, WB_REQ, WB_ANS, CLEAR), plus req-ready stall cycles, plus answer wait cycles.
- All-clean cache of N lines: done rises 2N+1 cycles after the request is sampled.
- `l2_req_*` is a registered output; the request is accepted on the edge where valid&rdy.
- At most one outstanding L2 transaction.

## Test plan
With `N_SETS`=4, `N_WAYS`=2 (8 lines):
- Reset during WB_REQ: all outputs 0 during reset and after it; no `dirty_clr_o`. A following request completes a full walk from `cnt`=0.
- All lines clean, `synch_l1dc_l2c_i` held high: exactly 8 `dir_rd_req_o` pulses. Done rises 17 cycles after sampling, stays high until sync drops, and falls 1 cycle later.
- Only set 2 way 1 (`cnt`=5) dirty, tag 0x1234: exactly one L2 request with addr=(0x1234<<8)|(2<<6). One `dirty_clr_o` pulse at idx=2, way=1. Done follows with 0 ready/answer stalls at cycle 20.
- Two dirty lines, `l2_req_rdy_i` held low for 3 cycles and answer delayed 4 cycles: `l2_req_valid_o`, address and data stable throughout; done delayed by exactly 7 cycles per line.
- `synch_l1dc_l2c_i` dropped after 3 cycles, with last line (`cnt`=7) dirty: walk completes, write-back issued for `cnt`=7, done high for exactly 1 cycle.
- Spurious `l2_ans_valid_i` in IDLE and in READ: no state change, `l2_ans_rdy_o`=0. Line valid=0/dirty=1: no write-back.

Source files
------------

// File: rtl/l1dc_sync_unit.sv
// l1dc_sync_unit: walks the L1 d-cache directory on a sync request, writes
// every valid+dirty line back to L2 (one transaction at a time), clears its
// dirty bit, then raises l2c_update_done_o until the request is withdrawn.
module l1dc_sync_unit #(
  parameter  int N_SETS  = 64,
  parameter  int N_WAYS  = 4,
  parameter  int LINE_W  = 512,
  parameter  int PADDR_W = 56,
  localparam int OFF_W   = $clog2(LINE_W / 8),
  localparam int SET_W   = $clog2(N_SETS),
  localparam int WB_W    = $clog2(N_WAYS),          // way bits inside cnt (0 for 1 way)
  localparam int WAY_W   = (WB_W > 0) ? WB_W : 1,
  localparam int TAG_W   = PADDR_W - SET_W - OFF_W,
  localparam int CNT_W   = SET_W + WB_W
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               synch_l1dc_l2c_i,
  output logic               l2c_update_done_o,
  output logic               busy_o,
  output logic               dir_rd_req_o,
  output logic [SET_W-1:0]   dir_idx_o,
  output logic [WAY_W-1:0]   dir_way_o,
  input  logic               dir_valid_i,
  input  logic               dir_dirty_i,
  input  logic [TAG_W-1:0]   dir_tag_i,
  input  logic [LINE_W-1:0]  dir_line_i,
  output logic               dirty_clr_o,
  output logic               l2_req_valid_o,
  input  logic               l2_req_rdy_i,
  output logic [PADDR_W-1:0] l2_req_addr_o,
  output logic [LINE_W-1:0]  l2_req_line_o,
  input  logic               l2_ans_valid_i,
  output logic               l2_ans_rdy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CHECK, S_WB_REQ, S_WB_ANS, S_CLEAR, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             wb_hit;
  logic             advance;

  assign last    = (cnt == CNT_W'(N_SETS * N_WAYS - 1));
  assign wb_hit  = dir_valid_i & dir_dirty_i;
  // move to the next line after a clean CHECK or a CLEAR, unless this was the last one
  assign advance = !last && (((state == S_CHECK) && !wb_hit) || (state == S_CLEAR));

  // line counter splits into set (high bits) and way (low bits)
  assign dir_idx_o = cnt[CNT_W-1 -: SET_W];
  generate
    if (WB_W > 0) begin : g_way
      assign dir_way_o = cnt[WB_W-1:0];
    end else begin : g_noway
      assign dir_way_o = '0;
    end
  endgenerate

  // state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // next-state logic; the walk never aborts once started
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (synch_l1dc_l2c_i) state_nxt = S_READ;
      S_READ:   state_nxt = S_CHECK;
      S_CHECK:  if (wb_hit)           state_nxt = S_WB_REQ;
                else if (last)        state_nxt = S_DONE;
                else                  state_nxt = S_READ;
      S_WB_REQ: if (l2_req_rdy_i)     state_nxt = S_WB_ANS;
      S_WB_ANS: if (l2_ans_valid_i)   state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = last ? S_DONE : S_READ;
      S_DONE:   if (!synch_l1dc_l2c_i) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy_o            = (state != S_IDLE);
    dir_rd_req_o      = (state == S_READ);
    l2_req_valid_o    = (state == S_WB_REQ);
    l2_ans_rdy_o      = (state == S_WB_ANS);
    dirty_clr_o       = (state == S_CLEAR);
    l2c_update_done_o = (state == S_DONE);
  end

  // line counter: cleared in IDLE, stepped after each finished line
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)            cnt <= '0;
    else if (state == S_IDLE) cnt <= '0;
    else if (advance)         cnt <= cnt + CNT_W'(1);
  end

  // write-back request registers, loaded only when a dirty line is found so
  // they hold steady for the whole WB_REQ stall
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      l2_req_addr_o <= '0;
      l2_req_line_o <= '0;
    end else if ((state == S_CHECK) && wb_hit) begin
      l2_req_addr_o <= {dir_tag_i, dir_idx_o, {OFF_W{1'b0}}};
      l2_req_line_o <= dir_line_i;
    end
  end

endmodule
